// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared types and line width for the L1/pmem arbitration path
package cache_types_pkg;

    localparam int LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DRAIN
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with a last_grant register
module rr_arbiter2
    import cache_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       update_en,
    output requester_t grant,
    output logic       grant_valid
);

    requester_t last_grant;

    assign grant_valid = req_i | req_d;

    // On a conflict the side that did not win last time gets the line port.
    always_comb begin
        grant = REQ_I;
        if (req_i && req_d) begin
            grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            grant = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_D;
        end else if (update_en && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares the pmem line port between the L1 icache and dcache
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = cache_types_pkg::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [31:0]           i_grant_count,
    output logic [31:0]           d_grant_count,
    output logic [31:0]           conflict_count
);

    import cache_types_pkg::*;

    arb_state_t state;
    requester_t grant;
    logic       grant_valid;
    logic       d_req;

    assign d_req = d_read | d_write;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (i_read),
        .req_d       (d_req),
        .update_en   (state == IDLE),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Gated by rst so a response landing on the reset cycle is dropped.
    assign i_resp = !rst && (state == SERVE_I) && pmem_resp;
    assign d_resp = !rst && (state == SERVE_D) && pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pmem_read      <= 1'b0;
            pmem_write     <= 1'b0;
            pmem_addr      <= '0;
            pmem_wdata     <= '0;
            i_grant_count  <= '0;
            d_grant_count  <= '0;
            conflict_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        if (i_read && d_req) begin
                            conflict_count <= conflict_count + 32'd1;
                        end
                        if (grant == REQ_I) begin
                            state      <= SERVE_I;
                            pmem_read  <= 1'b1;
                            pmem_write <= 1'b0;
                            pmem_addr  <= i_addr;
                            pmem_wdata <= '0;
                        end else begin
                            // A write wins over a simultaneous (illegal) read.
                            state      <= SERVE_D;
                            pmem_read  <= !d_write;
                            pmem_write <= d_write;
                            pmem_addr  <= d_addr;
                            pmem_wdata <= d_wdata;
                        end
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state         <= DRAIN;
                        pmem_read     <= 1'b0;
                        pmem_write    <= 1'b0;
                        i_grant_count <= i_grant_count + 32'd1;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state         <= DRAIN;
                        pmem_read     <= 1'b0;
                        pmem_write    <= 1'b0;
                        d_grant_count <= d_grant_count + 32'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [31:0]   i_grant_count;
    logic [31:0]   d_grant_count;
    logic [31:0]   conflict_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_read         (i_read),
        .i_addr         (i_addr),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_addr      (pmem_addr),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .i_grant_count  (i_grant_count),
        .d_grant_count  (d_grant_count),
        .conflict_count (conflict_count)
    );

    task automatic test_reset();
        rst = 1'b1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
        d_addr = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
            failures++; $display("FAIL reset_strobes got=%b want=0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        checks++;
        if (pmem_addr !== '0 || pmem_wdata !== '0) begin
            failures++; $display("FAIL reset_latches got addr=%h wdata_nonzero=%0d want 0", pmem_addr, pmem_wdata != '0);
        end
        checks++;
        if ({i_grant_count, d_grant_count, conflict_count} !== 96'd0) begin
            failures++; $display("FAIL reset_counters got i=%0d d=%0d c=%0d want 0", i_grant_count, d_grant_count, conflict_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_icache_read();
        logic [LW-1:0] pat = {32{8'hAA}};
        int strobes = 0;
        int bad_addr = 0;
        int early_resp = 0;
        @(negedge clk);
        i_read = 1; i_addr = 32'h0000_1000;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++; $display("FAIL icache_latency got pmem_read=%b want 0 before grant edge", pmem_read);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) begin
                pmem_resp = 1; pmem_rdata = pat;
            end
            #1;
            if (pmem_read === 1'b1) strobes++;
            if (pmem_addr !== 32'h0000_1000) bad_addr++;
            if (k < 5 && (i_resp !== 1'b0 || d_resp !== 1'b0)) early_resp++;
        end
        checks++;
        if (i_resp !== 1'b1 || i_rdata !== pat || d_resp !== 1'b0) begin
            failures++; $display("FAIL icache_resp got i_resp=%b d_resp=%b rdata_ok=%0d want 1 0 1", i_resp, d_resp, i_rdata === pat);
        end
        checks++;
        if (bad_addr != 0 || early_resp != 0) begin
            failures++; $display("FAIL icache_hold got bad_addr=%0d early_resp=%0d want 0 0", bad_addr, early_resp);
        end
        @(negedge clk);
        pmem_resp = 0; i_read = 0;
        #1;
        checks++;
        if (strobes != 5) begin
            failures++; $display("FAIL icache_strobe_cycles got=%0d want=5", strobes);
        end
        checks++;
        if (pmem_read !== 1'b0 || i_resp !== 1'b0 || i_grant_count !== 32'd1 || d_grant_count !== 32'd0) begin
            failures++; $display("FAIL icache_after got rd=%b resp=%b icnt=%0d dcnt=%0d want 0 0 1 0", pmem_read, i_resp, i_grant_count, d_grant_count);
        end
        @(negedge clk);
    endtask

    task automatic test_dcache_write();
        logic [LW-1:0] w0 = {8{32'h1234_5678}};
        int unstable = 0;
        @(negedge clk);
        d_write = 1; d_addr = 32'h8000_0040; d_wdata = w0;
        @(negedge clk);
        d_wdata = ~w0; d_addr = 32'h0;
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
            failures++; $display("FAIL dcache_strobe got wr=%b rd=%b want 1 0", pmem_write, pmem_read);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) pmem_resp = 1;
            #1;
            if (pmem_addr !== 32'h8000_0040 || pmem_wdata !== w0 || pmem_write !== 1'b1) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            failures++; $display("FAIL dcache_latched got unstable_cycles=%0d addr=%h want 0 8000_0040", unstable, pmem_addr);
        end
        checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            failures++; $display("FAIL dcache_resp got d_resp=%b i_resp=%b want 1 0", d_resp, i_resp);
        end
        @(negedge clk);
        pmem_resp = 0; d_write = 0;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || d_resp !== 1'b0 || d_grant_count !== 32'd1) begin
            failures++; $display("FAIL dcache_after got wr=%b resp=%b dcnt=%0d want 0 0 1", pmem_write, d_resp, d_grant_count);
        end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        i_read = 1; d_read = 1; i_addr = 32'h2000; d_addr = 32'h3000;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h2000 || conflict_count !== 32'd1) begin
            failures++; $display("FAIL conflict_first got rd=%b addr=%h cc=%0d want 1 2000 1", pmem_read, pmem_addr, conflict_count);
        end
        @(negedge clk);
        pmem_resp = 1;
        #1;
        checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
            failures++; $display("FAIL conflict_i_resp got i=%b d=%b want 1 0", i_resp, d_resp);
        end
        @(negedge clk);
        pmem_resp = 0; i_read = 0;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++; $display("FAIL conflict_drain got rd=%b want 0", pmem_read);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++; $display("FAIL conflict_idle got rd=%b want 0", pmem_read);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h3000 || conflict_count !== 32'd1) begin
            failures++; $display("FAIL conflict_second got rd=%b addr=%h cc=%0d want 1 3000 1", pmem_read, pmem_addr, conflict_count);
        end
        @(negedge clk);
        pmem_resp = 1;
        #1;
        checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            failures++; $display("FAIL conflict_d_resp got d=%b i=%b want 1 0", d_resp, i_resp);
        end
        @(negedge clk);
        pmem_resp = 0; d_read = 0;
        @(negedge clk);
        i_read = 1; d_read = 1;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_addr !== 32'h2000 || conflict_count !== 32'd2) begin
            failures++; $display("FAIL conflict_rr got addr=%h cc=%0d want 2000 2", pmem_addr, conflict_count);
        end
        d_read = 0;
        @(negedge clk);
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; i_read = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] base = i_grant_count;
        @(negedge clk);
        i_read = 1; i_addr = 32'h4000;
        @(negedge clk);
        @(negedge clk);
        pmem_resp = 1;
        #1;
        checks++;
        if (i_resp !== 1'b1) begin
            failures++; $display("FAIL b2b_first_resp got=%b want 1", i_resp);
        end
        @(negedge clk);
        pmem_resp = 0; i_addr = 32'h5000;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
            failures++; $display("FAIL b2b_drain got rd=%b resp=%b want 0 0", pmem_read, i_resp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++; $display("FAIL b2b_idle got rd=%b want 0", pmem_read);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h5000) begin
            failures++; $display("FAIL b2b_second got rd=%b addr=%h want 1 5000", pmem_read, pmem_addr);
        end
        @(negedge clk);
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; i_read = 0;
        #1;
        checks++;
        if (i_grant_count !== base + 32'd2) begin
            failures++; $display("FAIL b2b_count got=%0d want=%0d", i_grant_count, base + 32'd2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_read = 1; d_addr = 32'h6000;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1) begin
            failures++; $display("FAIL rstmid_serving got rd=%b want 1", pmem_read);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; d_read = 0; pmem_resp = 1;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_resp !== 1'b0) begin
            failures++; $display("FAIL rstmid_strobes got rd=%b wr=%b d_resp=%b want 0 0 0", pmem_read, pmem_write, d_resp);
        end
        @(negedge clk);
        pmem_resp = 0;
        #1;
        checks++;
        if ({i_grant_count, d_grant_count, conflict_count} !== 96'd0 || pmem_read !== 1'b0) begin
            failures++; $display("FAIL rstmid_counters got i=%0d d=%0d c=%0d rd=%b want 0", i_grant_count, d_grant_count, conflict_count, pmem_read);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.i_grant_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.i_grant_count;
        @(negedge clk);
        i_read = 1; i_addr = 32'h7000;
        @(negedge clk);
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; i_read = 0;
        #1;
        checks++;
        if (i_grant_count !== 32'd0) begin
            failures++; $display("FAIL counter_wrap got=%h want=00000000", i_grant_count);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
